pc_stack_unit: RTL and testbench

- Parametrised program counter with a hardware return-address stack.
- Drives its count onto the shared tri-state system bus when `pc_out` is asserted.
- Loads from the bus for jumps and calls; supports increment, call and return.
- Sits between the control sequencer and the bus, feeding MAR on instruction fetch.

---
 rtl/pc_stack_unit.sv | 98 +++++++++
 tb/tb_pc_stack_unit.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter with a hardware return-address stack.
// Drives its count onto the shared tri-state bus when pc_out is high and
// loads from the bus for jumps and calls.
// Optional feature macro: PC_RELBRANCH_EN adds a 'branch' input for
// PC-relative branches (PC <= PC + signed bus offset).

module pc_stack_unit #(
  parameter int              WIDTH        = 8,
  parameter int              DEPTH        = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             increment,
  input  logic             pc_out,
  input  logic             pc_in,
  input  logic             call,
  input  logic             ret,
`ifdef PC_RELBRANCH_EN
  input  logic             branch,
`endif
  inout  wire  [WIDTH-1:0] bus,
  output logic [WIDTH-1:0] pc_value,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_err
);

  localparam int SPW  = $clog2(DEPTH + 1);
  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SPW-1:0]   sp;
  logic [SPW-1:0]   sp_next;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] pc_plus1;
  logic             err_next;
  logic             push;
  logic [WIDTH-1:0] stack_mem [DEPTH];

  assign pc_plus1    = pc_value + WIDTH'(1);
  assign stack_full  = (sp == SPW'(DEPTH));
  assign stack_empty = (sp == '0);
  assign bus         = pc_out ? pc_value : 'z;

  // Resolve the highest-priority command into next PC, pointer and error state
  always_comb begin
    pc_next  = pc_value;
    sp_next  = sp;
    err_next = stack_err;
    push     = 1'b0;
    if (call) begin
      if (!stack_full) begin
        push    = 1'b1;
        sp_next = sp + SPW'(1);
        pc_next = bus;
      end else begin
        err_next = 1'b1;
      end
    end else if (ret) begin
      if (!stack_empty) begin
        pc_next = stack_mem[IDXW'(sp - SPW'(1))];
        sp_next = sp - SPW'(1);
      end else begin
        err_next = 1'b1;
      end
    end else if (pc_in) begin
      pc_next = bus;
`ifdef PC_RELBRANCH_EN
    end else if (branch) begin
      // A plain WIDTH-bit add is the mod-2^WIDTH sum with a sign-extended offset
      pc_next = pc_value + bus;
`endif
    end else if (increment) begin
      pc_next = pc_plus1;
    end
  end

  // PC, stack pointer and sticky error register with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_value  <= RESET_VECTOR;
      sp        <= '0;
      stack_err <= 1'b0;
    end else begin
      pc_value  <= pc_next;
      sp        <= sp_next;
      stack_err <= err_next;
    end
  end

  // Return-address storage; contents need no reset since sp gates every read
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      stack_mem[IDXW'(sp)] <= pc_plus1;
    end
  end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed self-checking testbench for pc_stack_unit (WIDTH=8, DEPTH=4,
// RESET_VECTOR=0). Branch scenarios compile only with PC_RELBRANCH_EN.

module tb_pc_stack_unit;

  logic       clock;
  logic       reset;
  logic       increment;
  logic       pc_out;
  logic       pc_in;
  logic       call;
  logic       ret;
`ifdef PC_RELBRANCH_EN
  logic       branch;
`endif
  wire  [7:0] bus;
  logic [7:0] pc_value;
  logic       stack_full;
  logic       stack_empty;
  logic       stack_err;

  logic [7:0] bus_drv;
  logic       bus_en;

  int tests_run;
  int tests_failed;

  assign bus = bus_en ? bus_drv : 'z;

  pc_stack_unit #(.WIDTH(8), .DEPTH(4), .RESET_VECTOR(8'h00)) dut (
    .clock       (clock),
    .reset       (reset),
    .increment   (increment),
    .pc_out      (pc_out),
    .pc_in       (pc_in),
    .call        (call),
    .ret         (ret),
`ifdef PC_RELBRANCH_EN
    .branch      (branch),
`endif
    .bus         (bus),
    .pc_value    (pc_value),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .stack_err   (stack_err)
  );

  // Free-running 10-unit clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Advance past one rising edge; inputs change and outputs are sampled here
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    reset     = 1'b0;
    increment = 1'b0;
    pc_out    = 1'b0;
    pc_in     = 1'b0;
    call      = 1'b0;
    ret       = 1'b0;
`ifdef PC_RELBRANCH_EN
    branch    = 1'b0;
`endif
    bus_en    = 1'b0;
    bus_drv   = 8'h00;
  endtask

  task automatic load_pc(input logic [7:0] value);
    idle();
    bus_en  = 1'b1;
    bus_drv = value;
    pc_in   = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    reset  = 1'b1;
    pc_out = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tests_run++;
    if (pc_value !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_pc: got %h expected %h", pc_value, 8'h00); end
    tests_run++;
    if (bus !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_bus: got %h expected %h", bus, 8'h00); end
    tests_run++;
    if ({stack_empty, stack_full, stack_err} !== 3'b100) begin tests_failed++; $display("[TB] FAIL reset_flags: got %b expected %b", {stack_empty, stack_full, stack_err}, 3'b100); end
  endtask

  task automatic test_increment();
    increment = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      tests_run++;
      if (bus !== 8'(i)) begin tests_failed++; $display("[TB] FAIL incr_bus_%0d: got %h expected %h", i, bus, 8'(i)); end
    end
    idle();
    // PC is 3; the bench drives 0x00, so any DUT drive would show through
    bus_en = 1'b1;
    #1;
    tests_run++;
    if (bus !== 8'h00) begin tests_failed++; $display("[TB] FAIL bus_released: got %h expected %h", bus, 8'h00); end
    tests_run++;
    if (pc_value !== 8'h03) begin tests_failed++; $display("[TB] FAIL incr_pc: got %h expected %h", pc_value, 8'h03); end
    idle();
  endtask

  task automatic test_wrap();
    load_pc(8'hFF);
    tests_run++;
    if (pc_value !== 8'hFF) begin tests_failed++; $display("[TB] FAIL jump_ff: got %h expected %h", pc_value, 8'hFF); end
    increment = 1'b1;
    tick();
    idle();
    tests_run++;
    if (pc_value !== 8'h00) begin tests_failed++; $display("[TB] FAIL wrap_pc: got %h expected %h", pc_value, 8'h00); end
    tests_run++;
    if ({stack_empty, stack_full, stack_err} !== 3'b100) begin tests_failed++; $display("[TB] FAIL wrap_flags: got %b expected %b", {stack_empty, stack_full, stack_err}, 3'b100); end
  endtask

  task automatic test_self_load();
    load_pc(8'h5A);
    pc_out = 1'b1;
    pc_in  = 1'b1;
    tick();
    idle();
    tests_run++;
    if (pc_value !== 8'h5A) begin tests_failed++; $display("[TB] FAIL self_load: got %h expected %h", pc_value, 8'h5A); end
  endtask

  task automatic test_call_return();
    logic [7:0] exp_pc [3];
    exp_pc = '{8'h40, 8'h41, 8'h42};
    load_pc(8'h10);
    bus_en  = 1'b1;
    bus_drv = 8'h40;
    call    = 1'b1;
    tick();
    idle();
    tests_run++;
    if (pc_value !== exp_pc[0]) begin tests_failed++; $display("[TB] FAIL call_pc: got %h expected %h", pc_value, exp_pc[0]); end
    tests_run++;
    if (stack_empty !== 1'b0) begin tests_failed++; $display("[TB] FAIL call_empty: got %b expected %b", stack_empty, 1'b0); end
    increment = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      tick();
      tests_run++;
      if (pc_value !== exp_pc[i]) begin tests_failed++; $display("[TB] FAIL call_incr_%0d: got %h expected %h", i, pc_value, exp_pc[i]); end
    end
    idle();
    ret = 1'b1;
    tick();
    idle();
    tests_run++;
    if (pc_value !== 8'h11) begin tests_failed++; $display("[TB] FAIL ret_pc: got %h expected %h", pc_value, 8'h11); end
    tests_run++;
    if (stack_empty !== 1'b1) begin tests_failed++; $display("[TB] FAIL ret_empty: got %b expected %b", stack_empty, 1'b1); end
  endtask

  task automatic test_overflow_underflow();
    logic [7:0] exp_ret [4];
    exp_ret = '{8'h23, 8'h22, 8'h21, 8'h01};
    load_pc(8'h00);
    for (int i = 0; i < 5; i++) begin
      bus_en  = 1'b1;
      bus_drv = 8'h20 + 8'(i);
      call    = 1'b1;
      tick();
      idle();
      if (i == 3) begin
        tests_run++;
        if ({stack_full, stack_err} !== 2'b10) begin tests_failed++; $display("[TB] FAIL fill_flags: got %b expected %b", {stack_full, stack_err}, 2'b10); end
      end
    end
    tests_run++;
    if (pc_value !== 8'h23) begin tests_failed++; $display("[TB] FAIL overflow_pc: got %h expected %h", pc_value, 8'h23); end
    tests_run++;
    if ({stack_full, stack_err} !== 2'b11) begin tests_failed++; $display("[TB] FAIL overflow_flags: got %b expected %b", {stack_full, stack_err}, 2'b11); end
    for (int i = 0; i < 4; i++) begin
      ret = 1'b1;
      tick();
      idle();
      tests_run++;
      if (pc_value !== exp_ret[i]) begin tests_failed++; $display("[TB] FAIL pop_%0d: got %h expected %h", i, pc_value, exp_ret[i]); end
    end
    tests_run++;
    if (stack_empty !== 1'b1) begin tests_failed++; $display("[TB] FAIL drained_empty: got %b expected %b", stack_empty, 1'b1); end
    ret = 1'b1;
    tick();
    idle();
    tests_run++;
    if (pc_value !== 8'h01) begin tests_failed++; $display("[TB] FAIL underflow_pc: got %h expected %h", pc_value, 8'h01); end
    tests_run++;
    if ({stack_empty, stack_err} !== 2'b11) begin tests_failed++; $display("[TB] FAIL underflow_flags: got %b expected %b", {stack_empty, stack_err}, 2'b11); end
  endtask

  task automatic test_priority();
    idle();
    reset = 1'b1;
    tick();
    idle();
    tests_run++;
    if (stack_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_clears_err: got %b expected %b", stack_err, 1'b0); end
    ret = 1'b1;
    tick();
    idle();
    tests_run++;
    if ({pc_value, stack_err} !== {8'h00, 1'b1}) begin tests_failed++; $display("[TB] FAIL empty_ret: got %h expected %h", {pc_value, stack_err}, {8'h00, 1'b1}); end
    bus_en    = 1'b1;
    bus_drv   = 8'h33;
    call      = 1'b1;
    pc_in     = 1'b1;
    increment = 1'b1;
    tick();
    idle();
    tests_run++;
    if (pc_value !== 8'h33) begin tests_failed++; $display("[TB] FAIL prio_pc: got %h expected %h", pc_value, 8'h33); end
    tests_run++;
    if ({stack_empty, stack_full} !== 2'b00) begin tests_failed++; $display("[TB] FAIL prio_flags: got %b expected %b", {stack_empty, stack_full}, 2'b00); end
    ret = 1'b1;
    tick();
    idle();
    tests_run++;
    if ({pc_value, stack_empty} !== {8'h01, 1'b1}) begin tests_failed++; $display("[TB] FAIL prio_one_entry: got %h expected %h", {pc_value, stack_empty}, {8'h01, 1'b1}); end
  endtask

  task automatic test_reset_mid_ret();
    bus_en  = 1'b1;
    bus_drv = 8'h33;
    call    = 1'b1;
    tick();
    idle();
    reset = 1'b1;
    ret   = 1'b1;
    tick();
    idle();
    tests_run++;
    if (pc_value !== 8'h00) begin tests_failed++; $display("[TB] FAIL rst_ret_pc: got %h expected %h", pc_value, 8'h00); end
    tests_run++;
    if ({stack_empty, stack_full, stack_err} !== 3'b100) begin tests_failed++; $display("[TB] FAIL rst_ret_flags: got %b expected %b", {stack_empty, stack_full, stack_err}, 3'b100); end
  endtask

`ifdef PC_RELBRANCH_EN
  task automatic test_branch();
    load_pc(8'h50);
    bus_en  = 1'b1;
    bus_drv = 8'hFE;
    branch  = 1'b1;
    tick();
    idle();
    tests_run++;
    if (pc_value !== 8'h4E) begin tests_failed++; $display("[TB] FAIL branch_back: got %h expected %h", pc_value, 8'h4E); end
    load_pc(8'hFF);
    bus_en    = 1'b1;
    bus_drv   = 8'h03;
    branch    = 1'b1;
    increment = 1'b1;
    tick();
    idle();
    tests_run++;
    if (pc_value !== 8'h02) begin tests_failed++; $display("[TB] FAIL branch_wrap: got %h expected %h", pc_value, 8'h02); end
  endtask
`endif

  // Run every scenario in order, then report
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    idle();
    reset = 1'b1;
    test_reset();
    test_increment();
    test_wrap();
    test_self_load();
    test_call_return();
    test_overflow_underflow();
    test_priority();
    test_reset_mid_ret();
`ifdef PC_RELBRANCH_EN
    test_branch();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
